apb_reg_rdif: RTL and testbench

Parametrised APB slave read interface that replaces the fixed three-register readback mux of the 8-bit timer. It decodes a binary register index, inserts a configurable number of wait states, returns registered read data with a clean zero value outside valid phases, and flags unmapped accesses on `pslverr`. It also emits a per-register read strobe so status registers can implement read-to-clear. It sits between the APB bus and the register bank of any peripheral in the codebase.

---
 rtl/apb_reg_rdif.sv | 156 +++++++++++++++
 tb/tb_apb_reg_rdif.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_reg_rdif.sv
// apb_reg_rdif: parametrised APB slave read interface for a flat register bank.
// Decodes a binary register index, inserts WAIT_CYCLES wait states, returns
// registered read data (zero outside the completion cycle), flags unmapped
// indices on pslverr and emits a one-hot read strobe for read-to-clear status.
module apb_reg_rdif #(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 3,
    parameter int ADDR_W      = 3,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                         pclk,
    input  logic                         preset,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS-1:0]          rd_strobe
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_W-1:0]      idx_q, idx_d;
    logic                   write_q, write_d;
    logic                   mapped_q, mapped_d;
    logic [DATA_W-1:0]      prdata_q, prdata_d;
    logic                   pready_q, pready_d;
    logic                   pslverr_q, pslverr_d;
    logic [NUM_REGS-1:0]    rd_strobe_q, rd_strobe_d;

    logic                   addr_mapped;
    logic                   enter_done;
    logic [DATA_W-1:0]      sel_data;
    logic [NUM_REGS-1:0]    sel_onehot;

    // Compare in 32 bits so NUM_REGS == 2**ADDR_W does not overflow the index width.
    assign addr_mapped = (32'(paddr) < 32'(NUM_REGS));

    // Select the register slice and strobe bit for the index being completed.
    // idx_d is the live paddr on a zero-wait setup and the latched index otherwise.
    always_comb begin
        sel_data   = '0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (32'(idx_d) == 32'(i)) begin
                sel_data      = reg_data[i*DATA_W +: DATA_W];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; response outputs are only non-zero
    // on the edge that enters DONE, so they fall back to zero one cycle later.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        write_d     = write_q;
        mapped_d    = mapped_q;
        prdata_d    = '0;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        rd_strobe_d = '0;
        enter_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    idx_d    = paddr;
                    write_d  = pwrite;
                    mapped_d = addr_mapped;
                    cnt_d    = WAIT_LD;
                    if (WAIT_LD == 4'd0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    // Master abandoned the transfer: no response, no strobe.
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (penable) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end
                end
                // psel=1, penable=0 here is a stray setup; hold state.
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (enter_done) begin
            pready_d  = 1'b1;
            pslverr_d = !mapped_d;
            if (mapped_d && !write_d) begin
                prdata_d    = sel_data;
                rd_strobe_d = sel_onehot;
            end
        end
    end

    // State, latched request and registered response with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            mapped_q    <= 1'b0;
            prdata_q    <= '0;
            pready_q    <= 1'b0;
            pslverr_q   <= 1'b0;
            rd_strobe_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            mapped_q    <= mapped_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            rd_strobe_q <= rd_strobe_d;
        end
    end

    assign prdata    = prdata_q;
    assign pready    = pready_q;
    assign pslverr   = pslverr_q;
    assign rd_strobe = rd_strobe_q;

endmodule

// File: tb/tb_apb_reg_rdif.sv
// Directed bench for apb_reg_rdif: three instances (0, 2 and 3 wait states)
// share the bus; psel is routed only to the instance under test.
module tb_apb_reg_rdif;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [2:0]  paddr;
    logic [23:0] reg_data;
    int          active;

    logic [2:0]  psel_v;
    logic [7:0]  prdata_v [3];
    logic [2:0]  pready_v, pslverr_v;
    logic [2:0]  strobe_v [3];
    logic [12:0] obs;          // {pready, pslverr, prdata, rd_strobe}

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    assign psel_v[0] = psel && (active == 0);
    assign psel_v[1] = psel && (active == 1);
    assign psel_v[2] = psel && (active == 2);

    apb_reg_rdif #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(3), .WAIT_CYCLES(0)) u_w0 (
        .pclk(pclk), .preset(preset), .psel(psel_v[0]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .reg_data(reg_data), .prdata(prdata_v[0]),
        .pready(pready_v[0]), .pslverr(pslverr_v[0]), .rd_strobe(strobe_v[0]));

    apb_reg_rdif #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(3), .WAIT_CYCLES(2)) u_w2 (
        .pclk(pclk), .preset(preset), .psel(psel_v[1]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .reg_data(reg_data), .prdata(prdata_v[1]),
        .pready(pready_v[1]), .pslverr(pslverr_v[1]), .rd_strobe(strobe_v[1]));

    apb_reg_rdif #(.DATA_W(8), .NUM_REGS(3), .ADDR_W(3), .WAIT_CYCLES(3)) u_w3 (
        .pclk(pclk), .preset(preset), .psel(psel_v[2]), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .reg_data(reg_data), .prdata(prdata_v[2]),
        .pready(pready_v[2]), .pslverr(pslverr_v[2]), .rd_strobe(strobe_v[2]));

    always_comb begin
        obs = '0;
        case (active)
            0: obs = {pready_v[0], pslverr_v[0], prdata_v[0], strobe_v[0]};
            1: obs = {pready_v[1], pslverr_v[1], prdata_v[1], strobe_v[1]};
            2: obs = {pready_v[2], pslverr_v[2], prdata_v[2], strobe_v[2]};
            default: obs = '0;
        endcase
    end

    // Advance one clock; outputs are examined 1 time unit after the edge.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic setup(input int inst, input logic wr, input logic [2:0] a);
        active  = inst;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
    endtask

    task automatic bus_idle();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 3'd0;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        bus_idle();
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            active = k;
            #1;
            checks++;
            if (obs !== 13'h0) begin
                errors++;
                $display("FAIL reset_inst%0d: got %h expected %h", k, obs, 13'h0);
            end
        end
        preset = 1'b0;
        step();
    endtask

    task automatic test_read_w0();
        setup(0, 1'b0, 3'd1);
        step();
        penable = 1'b1;
        checks++;
        if (obs !== {1'b1, 1'b0, 8'h5A, 3'b010}) begin
            errors++;
            $display("FAIL read_w0_done: got %h expected %h", obs, {1'b1, 1'b0, 8'h5A, 3'b010});
        end
        bus_idle();
        step();
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL read_w0_after: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_read_wait2();
        setup(1, 1'b0, 3'd2);
        step();
        penable = 1'b1;
        reg_data[23:16] = 8'h3C;   // changes during the first wait cycle
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL wait2_cycle1: got %h expected %h", obs, 13'h0);
        end
        step();
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL wait2_cycle2: got %h expected %h", obs, 13'h0);
        end
        step();
        checks++;
        if (obs !== {1'b1, 1'b0, 8'h3C, 3'b100}) begin
            errors++;
            $display("FAIL wait2_done: got %h expected %h", obs, {1'b1, 1'b0, 8'h3C, 3'b100});
        end
        bus_idle();
        step();
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL wait2_after: got %h expected %h", obs, 13'h0);
        end
        reg_data[23:16] = 8'hC3;
    endtask

    task automatic test_unmapped();
        setup(0, 1'b0, 3'd5);
        step();
        penable = 1'b1;
        checks++;
        if (obs !== {1'b1, 1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL unmapped_read5: got %h expected %h", obs, {1'b1, 1'b1, 8'h00, 3'b000});
        end
        bus_idle();
        step();
        setup(0, 1'b1, 3'd7);
        step();
        penable = 1'b1;
        checks++;
        if (obs !== {1'b1, 1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL unmapped_write7: got %h expected %h", obs, {1'b1, 1'b1, 8'h00, 3'b000});
        end
        bus_idle();
        step();
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL unmapped_after: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_write_mapped();
        setup(1, 1'b1, 3'd0);
        step();
        penable = 1'b1;
        paddr   = 3'd6;            // post-setup change must be ignored
        step();
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL write0_wait: got %h expected %h", obs, 13'h0);
        end
        step();
        checks++;
        if (obs !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL write0_done: got %h expected %h", obs, {1'b1, 1'b0, 8'h00, 3'b000});
        end
        bus_idle();
        step();
    endtask

    task automatic test_abort();
        // psel dropped in the wait phase: no response at all.
        setup(1, 1'b0, 3'd1);
        step();
        penable = 1'b1;
        step();
        bus_idle();
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs !== 13'h0) begin
                errors++;
                $display("FAIL abort_cycle%0d: got %h expected %h", c, obs, 13'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        setup(2, 1'b0, 3'd1);
        step();
        penable = 1'b1;            // first wait cycle
        step();
        preset = 1'b1;             // second wait cycle
        step();
        checks++;
        if (obs !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", obs, 13'h0);
        end
        preset = 1'b0;
        bus_idle();
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (obs !== 13'h0) begin
                errors++;
                $display("FAIL reset_mid_quiet%0d: got %h expected %h", c, obs, 13'h0);
            end
        end
        setup(2, 1'b0, 3'd0);
        step();
        penable = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (obs[12] !== 1'b0 && c < 2) begin
                errors++;
                $display("FAIL reset_then_read_wait%0d: got pready %b expected 0", c, obs[12]);
            end
            if (c == 2 && obs !== {1'b1, 1'b0, 8'h11, 3'b001}) begin
                errors++;
                $display("FAIL reset_then_read: got %h expected %h", obs, {1'b1, 1'b0, 8'h11, 3'b001});
            end
        end
        bus_idle();
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'h11;
        exp_d[1] = 8'h5A;
        exp_d[2] = 8'hC3;
        for (int k = 0; k < 3; k++) begin
            setup(0, 1'b0, 3'(k));
            step();
            penable = 1'b1;
            checks++;
            if (obs !== {1'b1, 1'b0, exp_d[k], 3'(1 << k)}) begin
                errors++;
                $display("FAIL b2b_done%0d: got %h expected %h", k, obs, {1'b1, 1'b0, exp_d[k], 3'(1 << k)});
            end
            step();
            checks++;
            if (obs !== 13'h0) begin
                errors++;
                $display("FAIL b2b_gap%0d: got %h expected %h", k, obs, 13'h0);
            end
        end
        bus_idle();
        step();
    endtask

    initial begin
        active   = 0;
        preset   = 1'b1;
        reg_data = {8'hC3, 8'h5A, 8'h11};
        bus_idle();
        test_reset();
        test_read_w0();
        test_read_wait2();
        test_unmapped();
        test_write_mapped();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish before 100000");
        $fatal(1);
    end

endmodule
